// File: rtl/segre_dcache_ctrl_if.sv
// Memory-stage request/response bus of the data-cache controller, plus the
// access-size type it carries.

package segre_dcache_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memop_data_type_e;
endpackage

interface segre_dcache_ctrl_if #(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned WORD_SIZE = 32
) ();
  logic                                req_valid_i;
  logic                                req_ready_o;
  logic                                req_store_i;
  logic [ADDR_SIZE-1:0]                req_addr_i;
  segre_dcache_pkg::memop_data_type_e  req_type_i;
  logic [WORD_SIZE-1:0]                req_data_i;
  logic                                rsp_valid_o;
  logic                                rsp_err_o;
  logic [WORD_SIZE-1:0]                rsp_data_o;

  // Memory stage side.
  modport master (
    output req_valid_i, req_store_i, req_addr_i, req_type_i, req_data_i,
    input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o
  );

  // Cache controller side.
  modport slave (
    input  req_valid_i, req_store_i, req_addr_i, req_type_i, req_data_i,
    output req_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o
  );
endinterface

// File: rtl/segre_dcache_ctrl.sv
// Data-cache controller: one load/store at a time. Tag lookup, then either a
// data-array access (hit) or an MMU lane fetch, tag/data fill and replay (miss).
// Flush requests are deferred until the controller is idle.

module segre_dcache_ctrl
  import segre_dcache_pkg::*;
#(
  parameter int unsigned ADDR_SIZE         = 32,
  parameter int unsigned WORD_SIZE         = 32,
  parameter int unsigned DCACHE_LANE_SIZE  = 128,
  parameter int unsigned DCACHE_INDEX_SIZE = 2,
  parameter int unsigned DCACHE_BYTE_SIZE  = 4
) (
  input  logic                          clk_i,
  input  logic                          rsn_i,
  segre_dcache_ctrl_if.slave            req_if,
  input  logic                          flush_i,
  output logic                          tag_req_o,
  output logic                          tag_mmu_data_o,
  output logic                          tag_invalidate_o,
  output logic [ADDR_SIZE-1:0]          tag_addr_o,
  output logic [DCACHE_INDEX_SIZE-1:0]  tag_lru_index_o,
  input  logic                          tag_hit_i,
  input  logic                          tag_miss_i,
  output logic                          data_rd_o,
  output logic                          data_wr_o,
  output logic                          data_mem_wr_o,
  output logic [ADDR_SIZE-1:0]          data_addr_o,
  output memop_data_type_e              data_type_o,
  output logic [WORD_SIZE-1:0]          data_wdata_o,
  output logic [DCACHE_LANE_SIZE-1:0]   data_mem_data_o,
  input  logic [WORD_SIZE-1:0]          data_rdata_i,
  output logic                          mmu_miss_o,
  output logic                          mmu_access_o,
  output logic                          mmu_store_o,
  output logic [ADDR_SIZE-1:0]          mmu_addr_o,
  output logic [DCACHE_LANE_SIZE-1:0]   mmu_data_o,
  input  logic                          mmu_data_rdy_i,
  input  logic [DCACHE_LANE_SIZE-1:0]   mmu_data_i,
  input  logic [DCACHE_INDEX_SIZE-1:0]  mmu_lru_index_i
);

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, FILL, ACCESS, DONE} state_e;

  state_e                         state_q, state_d;
  logic                           flush_pend_q, flush_pend_d;
  logic                           store_q, store_d;
  logic [ADDR_SIZE-1:0]           addr_q, addr_d;
  memop_data_type_e               type_q, type_d;
  logic [WORD_SIZE-1:0]           wdata_q, wdata_d;
  logic                           err_q, err_d;
  logic [DCACHE_LANE_SIZE-1:0]    lane_q, lane_d;
  logic [DCACHE_INDEX_SIZE-1:0]   lru_q, lru_d;
  logic                           misaligned;

  // Alignment rule on the incoming request.
  always_comb begin
    misaligned = ((req_if.req_type_i == HALF) && req_if.req_addr_i[0]) ||
                 ((req_if.req_type_i == WORD) && (req_if.req_addr_i[1:0] != 2'b00));
  end

  // Next-state and output decode; every output is forced low while in reset.
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    store_d      = store_q;
    addr_d       = addr_q;
    type_d       = type_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    lane_d       = lane_q;
    lru_d        = lru_q;

    req_if.req_ready_o = 1'b0;
    req_if.rsp_valid_o = 1'b0;
    req_if.rsp_err_o   = 1'b0;
    req_if.rsp_data_o  = '0;
    tag_req_o          = 1'b0;
    tag_mmu_data_o     = 1'b0;
    tag_invalidate_o   = 1'b0;
    tag_addr_o         = '0;
    tag_lru_index_o    = '0;
    data_rd_o          = 1'b0;
    data_wr_o          = 1'b0;
    data_mem_wr_o      = 1'b0;
    data_addr_o        = '0;
    data_type_o        = BYTE;
    data_wdata_o       = '0;
    data_mem_data_o    = '0;
    mmu_miss_o         = 1'b0;
    mmu_access_o       = 1'b0;
    mmu_store_o        = 1'b0;
    mmu_addr_o         = '0;
    mmu_data_o         = '0;

    if (!rsn_i) begin
      // A flush arriving while busy is remembered; repeats collapse into one.
      if ((state_q != IDLE) && flush_i) flush_pend_d = 1'b1;

      case (state_q)
        IDLE: begin
          if (flush_i || flush_pend_q) begin
            tag_invalidate_o = 1'b1;
            flush_pend_d     = 1'b0;
          end else begin
            req_if.req_ready_o = 1'b1;
            if (req_if.req_valid_i) begin
              store_d = req_if.req_store_i;
              addr_d  = req_if.req_addr_i;
              type_d  = req_if.req_type_i;
              wdata_d = req_if.req_data_i;
              err_d   = misaligned;
              if (misaligned) begin
                state_d = DONE;
              end else begin
                tag_req_o  = 1'b1;
                tag_addr_o = req_if.req_addr_i;
                state_d    = LOOKUP;
              end
            end
          end
        end
        LOOKUP: begin
          if (tag_hit_i)       state_d = ACCESS;
          else if (tag_miss_i) state_d = MISS;
        end
        MISS: begin
          mmu_miss_o   = 1'b1;
          mmu_access_o = 1'b1;
          mmu_addr_o   = {addr_q[ADDR_SIZE-1:DCACHE_BYTE_SIZE], {DCACHE_BYTE_SIZE{1'b0}}};
          if (mmu_data_rdy_i) begin
            lane_d  = mmu_data_i;
            lru_d   = mmu_lru_index_i;
            state_d = FILL;
          end
        end
        FILL: begin
          tag_mmu_data_o  = 1'b1;
          tag_addr_o      = addr_q;
          tag_lru_index_o = lru_q;
          data_mem_wr_o   = 1'b1;
          data_mem_data_o = lane_q;
          data_addr_o     = addr_q;
          state_d         = ACCESS;
        end
        ACCESS: begin
          data_addr_o = addr_q;
          data_type_o = type_q;
          if (store_q) begin
            // Write-through: data array and MMU see the store in the same cycle.
            data_wr_o    = 1'b1;
            data_wdata_o = wdata_q;
            mmu_store_o  = 1'b1;
            mmu_access_o = 1'b1;
            mmu_addr_o   = addr_q;
            mmu_data_o   = DCACHE_LANE_SIZE'(wdata_q);
          end else begin
            data_rd_o = 1'b1;
          end
          state_d = DONE;
        end
        DONE: begin
          req_if.rsp_valid_o = 1'b1;
          req_if.rsp_err_o   = err_q;
          req_if.rsp_data_o  = (store_q || err_q) ? '0 : data_rdata_i;
          state_d            = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and request-latch registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      store_q      <= 1'b0;
      addr_q       <= '0;
      type_q       <= BYTE;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      lane_q       <= '0;
      lru_q        <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      store_q      <= store_d;
      addr_q       <= addr_d;
      type_q       <= type_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      lane_q       <= lane_d;
      lru_q        <= lru_d;
    end
  end

endmodule

// File: tb/tb_segre_dcache_ctrl.sv
// Bench for segre_dcache_ctrl: models tag/data arrays and the MMU around the
// controller, and predicts every response from a byte-level memory model.

module tb_segre_dcache_ctrl;
  import segre_dcache_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned WW = 32;
  localparam int unsigned LW = 128;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  segre_dcache_ctrl_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW)) dut_if ();

  logic          tag_req, tag_mmu_data, tag_inv;
  logic [AW-1:0] tag_addr;
  logic [IW-1:0] tag_lru;
  logic          tag_hit = 1'b0, tag_miss = 1'b0;
  logic          data_rd, data_wr, data_mem_wr;
  logic [AW-1:0] data_addr;
  memop_data_type_e data_type;
  logic [WW-1:0] data_wdata;
  logic [LW-1:0] data_mem_data;
  logic [WW-1:0] data_rdata = '0;
  logic          mmu_miss, mmu_access, mmu_store;
  logic [AW-1:0] mmu_addr;
  logic [LW-1:0] mmu_wdata;
  logic          mmu_rdy = 1'b0;
  logic [LW-1:0] mmu_lane = '0;
  logic [IW-1:0] mmu_lru = '0;

  segre_dcache_ctrl #(
    .ADDR_SIZE(AW), .WORD_SIZE(WW), .DCACHE_LANE_SIZE(LW),
    .DCACHE_INDEX_SIZE(IW), .DCACHE_BYTE_SIZE(4)
  ) dut (
    .clk_i(clk), .rsn_i(rst), .req_if(dut_if), .flush_i(flush),
    .tag_req_o(tag_req), .tag_mmu_data_o(tag_mmu_data), .tag_invalidate_o(tag_inv),
    .tag_addr_o(tag_addr), .tag_lru_index_o(tag_lru),
    .tag_hit_i(tag_hit), .tag_miss_i(tag_miss),
    .data_rd_o(data_rd), .data_wr_o(data_wr), .data_mem_wr_o(data_mem_wr),
    .data_addr_o(data_addr), .data_type_o(data_type), .data_wdata_o(data_wdata),
    .data_mem_data_o(data_mem_data), .data_rdata_i(data_rdata),
    .mmu_miss_o(mmu_miss), .mmu_access_o(mmu_access), .mmu_store_o(mmu_store),
    .mmu_addr_o(mmu_addr), .mmu_data_o(mmu_wdata),
    .mmu_data_rdy_i(mmu_rdy), .mmu_data_i(mmu_lane), .mmu_lru_index_i(mmu_lru)
  );

  int unsigned compared = 0, mismatched = 0, cyc = 0, inv_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Backing memory initial content; lane 0xFFFF_0000 holds 00,11,..,FF.
  function automatic logic [7:0] init_byte(logic [31:0] a);
    if (a[31:4] == 28'hFFFF000) return 8'(a[3:0] * 8'h11);
    return 8'((a * 32'h9E37_79B1) >> 24);
  endfunction

  // Reference model: flat byte memory and a 4-slot record of cached lanes.
  logic [7:0]  ref_mem [logic [31:0]];
  logic [27:0] ref_slot [4];
  logic        ref_val  [4];
  // Environment: MMU memory, tag slots and data-array lanes.
  logic [7:0]    mmu_mem [logic [31:0]];
  logic [LW-1:0] env_lane [logic [27:0]];
  logic [27:0]   env_slot [4];
  logic          env_val  [4];

  typedef struct { logic err; logic [31:0] data; int unsigned lat; int unsigned acc; } exp_t;
  typedef struct { int unsigned wait_c; logic [1:0] lru; } mmu_t;
  exp_t sb_q[$];
  mmu_t mmu_q[$];

  function automatic logic [7:0] ref_byte(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] mmu_byte(logic [31:0] a);
    return mmu_mem.exists(a) ? mmu_mem[a] : init_byte(a);
  endfunction

  function automatic int unsigned nbytes(memop_data_type_e t);
    return (t == BYTE) ? 1 : (t == HALF) ? 2 : 4;
  endfunction

  function automatic void ref_clear();
    for (int i = 0; i < 4; i++) ref_val[i] = 1'b0;
  endfunction

  // Predict the response of an accepted request and the MMU behaviour it needs.
  function automatic void ref_accept(logic st, logic [31:0] a, memop_data_type_e t, logic [31:0] d);
    exp_t e;
    mmu_t m;
    logic hit;
    e.acc  = cyc;
    e.data = '0;
    e.err  = ((t == HALF) && a[0]) || ((t == WORD) && (a[1:0] != 2'b00));
    e.lat  = 1;
    if (!e.err) begin
      hit = 1'b0;
      for (int i = 0; i < 4; i++) if (ref_val[i] && ref_slot[i] == a[31:4]) hit = 1'b1;
      if (hit) e.lat = 3;
      else begin
        m.wait_c = $urandom_range(2, 6);
        m.lru    = 2'($urandom_range(0, 3));
        mmu_q.push_back(m);
        ref_slot[m.lru] = a[31:4];
        ref_val[m.lru]  = 1'b1;
        e.lat = 4 + m.wait_c;
      end
      for (int i = 0; i < int'(nbytes(t)); i++) begin
        if (st) ref_mem[32'(a + i)] = d[8*i +: 8];
        else    e.data[8*i +: 8]    = ref_byte(32'(a + i));
      end
    end
    sb_q.push_back(e);
  endfunction

  // Monitor: pops the scoreboard on every response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dut_if.rsp_valid_o) begin
          if (sb_q.size() == 0) chk("unexpected_rsp", 1, 0);
          else begin
            e = sb_q.pop_front();
            chk("rsp_err", dut_if.rsp_err_o, e.err);
            chk("rsp_data", dut_if.rsp_data_o, e.data);
            chk("latency", cyc - e.acc, e.lat);
          end
        end
        if (tag_inv) begin
          inv_cnt++;
          chk("inv_blocks_ready", dut_if.req_ready_o, 0);
        end
      end
    end
  end

  // Environment: tag array, data array and MMU responders.
  initial begin : env
    logic nx_hit, nx_miss, nx_rdv, nx_rdy, hit, active;
    logic [31:0] nx_rdata;
    logic [LW-1:0] nx_lane, ln, msk;
    logic [IW-1:0] nx_lru;
    int unsigned mcnt;
    mmu_t cur;
    active = 1'b0; mcnt = 0; cur.wait_c = 0; cur.lru = '0;
    for (int i = 0; i < 4; i++) begin env_val[i] = 1'b0; env_slot[i] = '0; end
    forever begin
      @(negedge clk);
      nx_hit = 0; nx_miss = 0; nx_rdv = 0; nx_rdy = 0; nx_rdata = '0; nx_lane = '0; nx_lru = '0;
      if (rst) active = 1'b0;
      else begin
        if (tag_req) begin
          hit = 1'b0;
          for (int i = 0; i < 4; i++) if (env_val[i] && env_slot[i] == tag_addr[31:4]) hit = 1'b1;
          nx_hit = hit; nx_miss = !hit;
        end
        if (tag_inv) for (int i = 0; i < 4; i++) env_val[i] = 1'b0;
        if (tag_mmu_data) begin
          chk("fill_lru", tag_lru, cur.lru);
          env_slot[tag_lru] = tag_addr[31:4];
          env_val[tag_lru]  = 1'b1;
        end
        if (data_mem_wr) env_lane[data_addr[31:4]] = data_mem_data;
        ln = env_lane.exists(data_addr[31:4]) ? env_lane[data_addr[31:4]] : '0;
        if (data_rd) begin
          ln = ln >> {data_addr[3:0], 3'b000};
          nx_rdv = 1'b1;
          nx_rdata = (data_type == BYTE) ? {24'h0, ln[7:0]} :
                     (data_type == HALF) ? {16'h0, ln[15:0]} : ln[31:0];
        end
        if (data_wr) begin
          msk = (data_type == BYTE) ? 128'hFF : (data_type == HALF) ? 128'hFFFF : 128'hFFFF_FFFF;
          msk = msk << {data_addr[3:0], 3'b000};
          env_lane[data_addr[31:4]] = (ln & ~msk) | ((LW'(data_wdata) << {data_addr[3:0], 3'b000}) & msk);
        end
        if (mmu_store) begin
          chk("store_pair", {data_wr, mmu_access}, 2'b11);
          for (int i = 0; i < int'(nbytes(data_type)); i++) mmu_mem[32'(mmu_addr + i)] = mmu_wdata[8*i +: 8];
        end
        if (!mmu_miss) active = 1'b0;
        else begin
          if (!active) begin
            active = 1'b1; mcnt = 1;
            chk("mmu_addr_lane_aligned", {28'h0, mmu_addr[3:0]}, 0);
            if (mmu_q.size() == 0) begin chk("mmu_unexpected_miss", 1, 0); cur.wait_c = 2; end
            else cur = mmu_q.pop_front();
          end else mcnt++;
          if (mcnt == cur.wait_c - 1) begin
            nx_rdy = 1'b1; nx_lru = cur.lru;
            for (int i = 0; i < 16; i++) nx_lane[8*i +: 8] = mmu_byte(32'(mmu_addr + i));
          end
        end
      end
      @(posedge clk); #1;
      tag_hit    = nx_hit;
      tag_miss   = nx_miss;
      data_rdata = nx_rdv ? nx_rdata : $urandom();
      mmu_rdy    = nx_rdy;
      mmu_lane   = nx_rdy ? nx_lane : {$urandom(), $urandom(), $urandom(), $urandom()};
      mmu_lru    = nx_rdy ? nx_lru : IW'($urandom());
    end
  end

  // Drive one request (optionally with a simultaneous flush) until accepted.
  task automatic issue(logic st, logic [31:0] a, memop_data_type_e t, logic [31:0] d, logic fl);
    int unsigned n = 0;
    dut_if.req_valid_i = 1'b1;
    dut_if.req_store_i = st;
    dut_if.req_addr_i  = a;
    dut_if.req_type_i  = t;
    dut_if.req_data_i  = d;
    flush = fl;
    forever begin
      @(negedge clk);
      if (flush) ref_clear();
      if (dut_if.req_ready_o && dut_if.req_valid_i) begin
        ref_accept(st, a, t, d);
        break;
      end
      n++;
      if (n > 200) begin chk("accept_timeout", 0, 1); break; end
      @(posedge clk); #1;
      flush = 1'b0;
    end
    @(posedge clk); #1;
    flush = 1'b0;
    dut_if.req_valid_i = 1'b0;
    dut_if.req_data_i  = $urandom();
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(negedge clk);
    ref_clear();
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
      n++;
      if (n > 300) begin chk("rsp_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_mmu_miss();
    int unsigned n = 0;
    forever begin
      @(negedge clk);
      if (mmu_miss) break;
      n++;
      if (n > 50) begin chk("mmu_miss_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
  endtask

  logic        st;
  logic [31:0] a, d;
  memop_data_type_e t;
  int unsigned inv0;
  mmu_t mstuck;

  initial begin : main
    dut_if.req_valid_i = 1'b0;
    dut_if.req_store_i = 1'b0;
    dut_if.req_addr_i  = '0;
    dut_if.req_type_i  = BYTE;
    dut_if.req_data_i  = '0;
    ref_clear();
    for (int i = 0; i < 4; i++) ref_slot[i] = '0;

    // Reset: outputs quiet even with flush and a request pending.
    flush = 1'b1;
    dut_if.req_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", dut_if.req_ready_o, 0);
    chk("rst_rsp_valid", dut_if.rsp_valid_o, 0);
    chk("rst_invalidate", tag_inv, 0);
    chk("rst_tag_req", tag_req, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    dut_if.req_valid_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", dut_if.req_ready_o, 1);
    @(posedge clk); #1;

    // Directed: miss-fill of lane 0, hit load 0xBBAA9988, HALF store, misaligned.
    issue(1'b0, 32'hFFFF_0008, WORD, 32'h0, 1'b0); wait_idle();
    issue(1'b0, 32'hFFFF_0008, WORD, 32'h0, 1'b0); wait_idle();
    issue(1'b1, 32'hFFFF_000E, HALF, 32'h0000_CAFE, 1'b0); wait_idle();
    issue(1'b0, 32'hFFFF_000C, WORD, 32'h0, 1'b0); wait_idle();
    issue(1'b0, 32'hFFFF_0002, WORD, 32'h0, 1'b0); wait_idle();
    issue(1'b0, 32'hFFFF_000F, BYTE, 32'h0, 1'b0); wait_idle();

    // Directed: flush during a miss is deferred, issued once, then the lane misses.
    inv0 = inv_cnt;
    issue(1'b0, 32'hFFFF_0040, WORD, 32'h0, 1'b0);
    wait_mmu_miss();
    flush_pulse();
    flush_pulse();
    wait_idle();
    repeat (3) begin @(posedge clk); #1; end
    chk("flush_once", inv_cnt - inv0, 1);
    issue(1'b0, 32'hFFFF_0040, WORD, 32'h0, 1'b0); wait_idle();

    // Randomized traffic over 8 lanes (4 cache slots) with sporadic flushes.
    for (int k = 0; k < 150; k++) begin
      st = ($urandom_range(0, 9) < 4);
      t  = memop_data_type_e'($urandom_range(0, 2));
      a  = 32'hFFFF_0000 + ($urandom_range(0, 7) << 4) + $urandom_range(0, 15);
      if ($urandom_range(0, 9) != 0) begin
        if (t == HALF) a[0] = 1'b0;
        else if (t == WORD) a[1:0] = 2'b00;
      end
      d = $urandom();
      issue(st, a, t, d, ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 14) == 0) flush_pulse();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_idle();

    // Reset in the middle of a miss abandons it without a response.
    mstuck.wait_c = 60; mstuck.lru = 2'd0;
    mmu_q.push_back(mstuck);
    dut_if.req_valid_i = 1'b1;
    dut_if.req_store_i = 1'b0;
    dut_if.req_addr_i  = 32'hFFFF_0100;
    dut_if.req_type_i  = WORD;
    @(negedge clk);
    chk("late_ready", dut_if.req_ready_o, 1);
    @(posedge clk); #1;
    dut_if.req_valid_i = 1'b0;
    wait_mmu_miss();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_miss_mmu_miss", mmu_miss, 0);
    chk("rst_mid_miss_rsp", dut_if.rsp_valid_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_rst", dut_if.req_ready_o, 1);
    chk("miss_dropped", mmu_miss, 0);
    repeat (10) begin @(posedge clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
